if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues requests to
//  instruction memory (variable-latency req/ack) and drives the IF/ID pipeline register.
//  It consumes the hazard unit's stall (PC/IF_ID write-disable) and the ID stage's
//  branch/jump flush. It sits directly upstream of ID and of the hazard detection unit.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0000  instruction word placed in IF/ID for a bubble
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   asynchronous reset, active-low
//  start_i        in   1   fetch enable; sampled only in IDLE
//  stall_i        in   1   load-use stall from hazard unit: hold IF/ID and PC
//  flush_i        in   1   taken branch/jump in ID: squash IF/ID and redirect the PC
//  target_i       in   32  redirect address; valid when flush_i=1
//  imem_req_o     out  1   instruction memory request
//  imem_addr_o    out  32  request address; held stable until imem_ack_i
//  imem_ack_i     in   1   memory response valid; may assert in the same cycle as req
//  imem_data_i    in   32  instruction word; valid when imem_ack_i=1
//  pc_o           out  32  next fetch address (architectural PC)
//  if_id_pc4_o    out  32  IF/ID register: address of the fetched instruction + 4
//  if_id_inst_o   out  32  IF/ID register: instruction
//  if_id_valid_o  out  1   IF/ID register: 1 = real instruction, 0 = bubble
// BEHAVIOUR
//  Reset (rst_i=0, takes effect without a clock edge): state=IDLE, pc_o=RESET_PC,
//   imem_req_o=0, imem_addr_o=RESET_PC, if_id_pc4_o=0, if_id_inst_o=NOP_INST,
//   if_id_valid_o=0, kill=0, buffer empty. Reset mid-request abandons the request.
//  Bubble = {pc4=0, inst=NOP_INST, valid=0}. All other registers update on the rising clk_i edge.
//  States: IDLE, FETCH, HOLD.
//  IDLE: imem_req_o=0. If start_i=1, go to FETCH; the first request is issued next cycle.
//  FETCH: imem_req_o=1.
//   - New request: imem_addr_o<=pc_o. The address stays stable until the ack cycle, inclusive.
//   - ack and kill=1: discard the data, kill<=0, issue a new request at pc_o
//     (pc_o already holds the redirect target).
//   - ack, kill=0, flush_i=1: discard the data, pc_o<=target_i, IF/ID<=bubble.
//   - ack, no flush, stall_i=0: IF/ID<={imem_addr_o+4, imem_data_i, 1}, pc_o<=imem_addr_o+4.
//   - ack, no flush, stall_i=1: buffer<={imem_addr_o+4, imem_data_i}, pc_o<=imem_addr_o+4,
//     IF/ID holds, go to HOLD.
//   - no ack, flush_i=1: pc_o<=target_i, kill<=1, IF/ID<=bubble. The request stays at the
//     old address until it is acked.
//   - no ack, stall_i=0: IF/ID<=bubble. No ack, stall_i=1: IF/ID holds.
//  HOLD: imem_req_o=0.
//   - flush_i=1: discard the buffer, pc_o<=target_i, IF/ID<=bubble, go to FETCH.
//   - stall_i=1: hold.
//   - stall_i=0: IF/ID<={buffer, valid=1}, go to FETCH.
//  Priority: flush_i over stall_i in every state; IF/ID receives a bubble.
//  Throughput/latency: with a same-cycle ack, one instruction per cycle. An instruction
//   appears on the if_id_* outputs the cycle after its ack. Each memory wait cycle
//   inserts one bubble.
//  Width: pc arithmetic is 32-bit modulo 2^32 (0xFFFF_FFFC+4 wraps to 0). No alignment check.
//  Invariant: no instruction is lost or duplicated across a stall. At most one request is
//   outstanding.
// TESTING
//  1 Reset, start_i=1, ack tied to req, data=addr -> imem_addr_o 0,4,8; if_id_inst_o 0,4,8
//    one cycle later; if_id_pc4_o 4,8,12; valid=1.
//  2 stall_i=1 for 2 cycles while acking 0x8 -> IF/ID holds inst 0x4, req=0 in HOLD;
//    after release IF/ID=0x8 then 0xC. No skip, no repeat.
//  3 ack delayed 3 cycles on addr 0x10; flush_i with target 0x40 in cycle 1 -> addr stays
//    0x10 until ack, data discarded, next req addr 0x40, valid=0 until 0x40 is delivered.
//  4 flush_i=1 and stall_i=1 together, target 0x80 -> IF/ID bubble next cycle,
//    next request 0x80.
//  5 rst_i low mid-request (no clock edge) -> imem_req_o=0, pc_o=RESET_PC, valid=0
//    immediately. After release, stays in IDLE until start_i.
//  6 PC 0xFFFF_FFFC fetched -> pc_o and if_id_pc4_o wrap to 0x0000_0000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, runs one outstanding imem req/ack transaction, drives IF/ID.
// Latency: an acked word reaches IF/ID on the next edge; one instruction per cycle with same-cycle ack.
// Backpressure: stall_i parks an acked word in a one-entry buffer and drops req; flush_i wins over stall_i.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        kill_q, kill_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_vld_q, ifid_vld_d;
    logic [31:0] addr_pc4;

    assign addr_pc4 = addr_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        buf_pc4_d   = buf_pc4_q;
        buf_inst_d  = buf_inst_q;
        ifid_pc4_d  = ifid_pc4_q;
        ifid_inst_d = ifid_inst_q;
        ifid_vld_d  = ifid_vld_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack_i) begin
                    if (kill_q) begin
                        // Response to a request already overtaken by a redirect.
                        kill_d = 1'b0;
                        if (flush_i) pc_d = target_i;
                        if (flush_i || !stall_i) begin
                            ifid_pc4_d  = 32'd0;
                            ifid_inst_d = NOP_INST;
                            ifid_vld_d  = 1'b0;
                        end
                    end else if (flush_i) begin
                        pc_d        = target_i;
                        ifid_pc4_d  = 32'd0;
                        ifid_inst_d = NOP_INST;
                        ifid_vld_d  = 1'b0;
                    end else if (!stall_i) begin
                        pc_d        = addr_pc4;
                        ifid_pc4_d  = addr_pc4;
                        ifid_inst_d = imem_data_i;
                        ifid_vld_d  = 1'b1;
                    end else begin
                        pc_d       = addr_pc4;
                        buf_pc4_d  = addr_pc4;
                        buf_inst_d = imem_data_i;
                        state_d    = HOLD;
                    end
                end else if (flush_i) begin
                    pc_d        = target_i;
                    kill_d      = 1'b1;
                    ifid_pc4_d  = 32'd0;
                    ifid_inst_d = NOP_INST;
                    ifid_vld_d  = 1'b0;
                end else if (!stall_i) begin
                    ifid_pc4_d  = 32'd0;
                    ifid_inst_d = NOP_INST;
                    ifid_vld_d  = 1'b0;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pc_d        = target_i;
                    ifid_pc4_d  = 32'd0;
                    ifid_inst_d = NOP_INST;
                    ifid_vld_d  = 1'b0;
                    state_d     = FETCH;
                end else if (!stall_i) begin
                    ifid_pc4_d  = buf_pc4_q;
                    ifid_inst_d = buf_inst_q;
                    ifid_vld_d  = 1'b1;
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh request starts whenever none is in flight next cycle, always at the new PC.
        addr_d = (state_q != FETCH || imem_ack_i) ? pc_d : addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            kill_q      <= 1'b0;
            buf_pc4_q   <= 32'd0;
            buf_inst_q  <= NOP_INST;
            ifid_pc4_q  <= 32'd0;
            ifid_inst_q <= NOP_INST;
            ifid_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            kill_q      <= kill_d;
            buf_pc4_q   <= buf_pc4_d;
            buf_inst_q  <= buf_inst_d;
            ifid_pc4_q  <= ifid_pc4_d;
            ifid_inst_q <= ifid_inst_d;
            ifid_vld_q  <= ifid_vld_d;
        end
    end

    assign imem_req_o    = (state_q == FETCH);
    assign imem_addr_o   = addr_q;
    assign pc_o          = pc_q;
    assign if_id_pc4_o   = ifid_pc4_q;
    assign if_id_inst_o  = ifid_inst_q;
    assign if_id_valid_o = ifid_vld_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed scenarios plus a randomized run of if_stage against a transaction-level fetch model.
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] target_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic [31:0] pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;

    if_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .flush_i(flush_i), .target_i(target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .pc_o(pc_o), .if_id_pc4_o(if_id_pc4_o), .if_id_inst_o(if_id_inst_o),
        .if_id_valid_o(if_id_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    logic [31:0] dxor = 32'd0;

    // Model: a fetch engine with an in-flight request record and a one-word park queue.
    typedef struct packed { logic [31:0] pc4; logic [31:0] inst; } word_t;
    bit          m_on;
    word_t       m_park[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    bit          m_req_stale;
    logic [31:0] m_pc4, m_inst;
    bit          m_vld;

    function automatic bit m_req();
        return m_on && (m_park.size() == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_on = 0; m_park.delete(); m_pc = 32'd0; m_req_addr = 32'd0;
        m_req_stale = 0; m_pc4 = 32'd0; m_inst = 32'd0; m_vld = 0;
    endtask

    task automatic m_bubble();
        m_pc4 = 32'd0; m_inst = 32'd0; m_vld = 0;
    endtask

    task automatic m_step();
        if (!rst_i) return;
        if (!m_on) begin
            if (start_i) begin m_on = 1; m_req_addr = m_pc; end
        end else if (m_park.size() != 0) begin
            if (flush_i) begin
                m_park.delete(); m_pc = target_i; m_bubble(); m_req_addr = m_pc;
            end else if (!stall_i) begin
                m_pc4 = m_park[0].pc4; m_inst = m_park[0].inst; m_vld = 1;
                m_park.delete(); m_req_addr = m_pc;
            end
        end else if (imem_ack_i) begin
            if (m_req_stale) begin
                m_req_stale = 0;
                if (flush_i) m_pc = target_i;
                if (flush_i || !stall_i) m_bubble();
            end else if (flush_i) begin
                m_pc = target_i; m_bubble();
            end else if (!stall_i) begin
                m_pc = m_req_addr + 32'd4; m_pc4 = m_pc; m_inst = imem_data_i; m_vld = 1;
            end else begin
                m_pc = m_req_addr + 32'd4;
                m_park.push_back('{pc4: m_pc, inst: imem_data_i});
            end
            m_req_addr = m_pc;
        end else if (flush_i) begin
            m_pc = target_i; m_req_stale = 1; m_bubble();
        end else if (!stall_i) begin
            m_bubble();
        end
    endtask

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("req", {31'd0, imem_req_o}, {31'd0, m_req()});
            chk("pc", pc_o, m_pc);
            chk("pc4", if_id_pc4_o, m_pc4);
            chk("inst", if_id_inst_o, m_inst);
            chk("valid", {31'd0, if_id_valid_o}, {31'd0, m_vld});
            if (m_req()) chk("addr", imem_addr_o, m_req_addr);
        end
    end

    // Drive one cycle of stimulus; the memory answers from the model's view of the request.
    task automatic step(input bit a, input bit s, input bit f, input logic [31:0] t);
        imem_ack_i  = a && m_req();
        imem_data_i = m_req_addr ^ dxor;
        stall_i     = s;
        flush_i     = f;
        target_i    = t;
        @(posedge clk_i);
        m_step();
        #1;
    endtask

    initial begin
        m_reset();
        #12 rst_i = 1'b1;
        @(posedge clk_i); #1;
        cmp_en = 1'b1;
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid_o}, 32'd0);

        // Back-to-back fetch with same-cycle ack, then a two-cycle stall on 0x8.
        start_i = 1'b1;
        step(1, 0, 0, 0);
        start_i = 1'b0;
        chk("t1_addr0", imem_addr_o, 32'h0);
        step(1, 0, 0, 0);
        chk("t1_inst0", if_id_inst_o, 32'h0);
        chk("t1_pc4_0", if_id_pc4_o, 32'h4);
        chk("t1_addr4", imem_addr_o, 32'h4);
        step(1, 0, 0, 0);
        chk("t1_inst4", if_id_inst_o, 32'h4);
        chk("t1_addr8", imem_addr_o, 32'h8);
        step(1, 1, 0, 0);
        chk("t2_hold_inst", if_id_inst_o, 32'h4);
        chk("t2_hold_req", {31'd0, imem_req_o}, 32'd0);
        step(1, 1, 0, 0);
        chk("t2_hold2_inst", if_id_inst_o, 32'h4);
        step(1, 0, 0, 0);
        chk("t2_rel_inst", if_id_inst_o, 32'h8);
        chk("t2_rel_addr", imem_addr_o, 32'hC);
        step(1, 0, 0, 0);
        chk("t2_next_inst", if_id_inst_o, 32'hC);

        // Flush while 0x10 waits for a late ack.
        step(0, 0, 1, 32'h40);
        chk("t3_addr_held", imem_addr_o, 32'h10);
        chk("t3_pc", pc_o, 32'h40);
        chk("t3_valid", {31'd0, if_id_valid_o}, 32'd0);
        step(0, 0, 0, 0);
        chk("t3_addr_held2", imem_addr_o, 32'h10);
        step(1, 0, 0, 0);
        chk("t3_addr_redir", imem_addr_o, 32'h40);
        chk("t3_discard", {31'd0, if_id_valid_o}, 32'd0);
        step(1, 0, 0, 0);
        chk("t3_inst40", if_id_inst_o, 32'h40);
        chk("t3_pc4_44", if_id_pc4_o, 32'h44);

        // Flush together with stall, in FETCH and in HOLD.
        step(1, 1, 1, 32'h80);
        chk("t4_valid", {31'd0, if_id_valid_o}, 32'd0);
        chk("t4_addr", imem_addr_o, 32'h80);
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h90);
        chk("t4h_valid", {31'd0, if_id_valid_o}, 32'd0);
        chk("t4h_addr", imem_addr_o, 32'h90);

        // PC wrap at the top of the address space.
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("t6_pc", pc_o, 32'h0);
        chk("t6_pc4", if_id_pc4_o, 32'h0);
        chk("t6_inst", if_id_inst_o, 32'hFFFF_FFFC);

        // Asynchronous reset while a request is outstanding.
        step(0, 0, 0, 0);
        rst_i = 1'b0;
        #1;
        m_reset();
        chk("t5_req", {31'd0, imem_req_o}, 32'd0);
        chk("t5_pc", pc_o, 32'h0);
        chk("t5_valid", {31'd0, if_id_valid_o}, 32'd0);
        step(1, 0, 0, 0);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("t5_idle", {31'd0, imem_req_o}, 32'd0);
        end

        // Randomized traffic.
        dxor = 32'h5A3C_96E1;
        start_i = 1'b1;
        step(1, 0, 0, 0);
        start_i = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 255), 2'b00};
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 12, t);
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
